// File: rtl/mac_dot_seq_if.sv
// Job/operand/result handshake bundle between producer, consumer and mac_dot_seq.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface mac_dot_seq_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_ready;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ready;

  modport slave (
    input  start, len, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );

  modport master (
    output start, len, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for the shared MAC: start->in_ready 2 cyc, last beat->res_valid 3 cyc;
// operands stall on in_ready (RUN only), result held until res_ready. Option MAC_SEQ_OVF_EN adds ovf_o.
module mac_dot_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_dot_seq_if.slave      job_if,
  output logic [DATA_W-1:0] mac_a_o,
  output logic [DATA_W-1:0] mac_b_o,
  output logic              mac_rst_o,
  input  logic [ACC_W-1:0]  mac_out_i,
  output logic              busy_o
`ifdef MAC_SEQ_OVF_EN
  , output logic            ovf_o
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic [DATA_W-1:0] mac_a_q, mac_a_d;
  logic [DATA_W-1:0] mac_b_q, mac_b_d;
  logic              mac_rst_q, mac_rst_d;
  logic [ACC_W-1:0]  res_q, res_d;
  logic              beat;

  assign beat = job_if.in_valid && job_if.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_if.start) state_d = (job_if.len != '0) ? CLEAR : DONE;
      CLEAR:   state_d = RUN;
      RUN:     if (beat && cnt_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    if (job_if.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    job_if.in_ready  = (state_q == RUN);
    job_if.res_valid = (state_q == DONE);
    busy_o           = (state_q != IDLE);
  end

  // Unaccepted cycles feed zeros so the MAC accumulator holds its value.
  always_comb begin
    cnt_d     = cnt_q;
    drain_d   = 1'b0;
    res_d     = res_q;
    mac_a_d   = beat ? job_if.in_a : '0;
    mac_b_d   = beat ? job_if.in_b : '0;
    mac_rst_d = (state_d == CLEAR);
    if (state_q == IDLE && job_if.start) begin
      cnt_d = job_if.len;
      if (job_if.len == '0) res_d = '0;
    end
    if (beat) cnt_d = cnt_q - LEN_W'(1);
    if (state_q == DRAIN) begin
      drain_d = ~drain_q;
      if (drain_q) res_d = mac_out_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_rst_q <= 1'b1;
      res_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_rst_q <= mac_rst_d;
      res_q     <= res_d;
    end
  end

  assign mac_a_o         = mac_a_q;
  assign mac_b_o         = mac_b_q;
  assign mac_rst_o       = mac_rst_q;
  assign job_if.res_data = res_q;

`ifdef MAC_SEQ_OVF_EN
  // Shadow keeps the low ACC_W bits plus a sticky carry, equivalent to an unbounded sum >= 2**ACC_W.
  logic [ACC_W-1:0]    shadow_q, shadow_d;
  logic                ovf_q, ovf_d;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      shadow_sum;

  always_comb begin
    prod       = job_if.in_a * job_if.in_b;
    shadow_sum = {1'b0, shadow_q} + (ACC_W+1)'(prod);
    shadow_d   = shadow_q;
    ovf_d      = ovf_q;
    if (state_q == IDLE || state_q == CLEAR) begin
      shadow_d = '0;
      ovf_d    = 1'b0;
    end else if (beat) begin
      shadow_d = shadow_sum[ACC_W-1:0];
      ovf_d    = ovf_q | shadow_sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf_o = ovf_q & (state_q == DONE);
`endif

endmodule
